// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: scans a {row,col} address into the island mux chain,
// latches it, settles, then issues a timed inject/tunnel pulse train. Optional: FG_PROG_VERIFY_EN.
module fg_prog_sequencer #(
    parameter int ROW_W      = 3,
    parameter int COL_W      = 5,
    parameter int NUM_ROWS   = 5,
    parameter int NUM_COLS   = 26,
    parameter int SETTLE_CYC = 8,
    parameter int PULSE_CYC  = 100,
    parameter int GAP_CYC    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ROW_W-1:0] cmd_row,
    input  logic [COL_W-1:0] cmd_col,
    input  logic             cmd_op,
    input  logic [7:0]       cmd_pulses,
    input  logic             abort,
`ifdef FG_PROG_VERIFY_EN
    input  logic             meas_pass,
`endif
    output logic             sh_clk,
    output logic             sh_data,
    output logic             sh_latch,
    output logic             mux_en,
    output logic             prog_inj,
    output logic             prog_tun,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic             rsp_abort,
    output logic [7:0]       rsp_count
);

    localparam int ADDR_W  = ROW_W + COL_W;
    localparam int MAX_SP  = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
    localparam int TIMER_W = $clog2(MAX_CYC) + 1;
    localparam int STEP_W  = $clog2(2 * ADDR_W);

    localparam logic [STEP_W-1:0]  STEP_LAST   = STEP_W'(2 * ADDR_W - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] PULSE_LOAD  = TIMER_W'(PULSE_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        SETTLE,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t              state_reg;
    logic [TIMER_W-1:0]  timer_reg;
    logic [STEP_W-1:0]   step_reg;
    logic [ADDR_W-1:0]   word_reg;
    logic                op_reg;
    logic [7:0]          pulses_reg;
    logic [7:0]          issued_reg;
    logic                addr_bad;
    logic                verify_stop;

    assign addr_bad = (int'(cmd_row) >= NUM_ROWS) || (int'(cmd_col) >= NUM_COLS);

`ifdef FG_PROG_VERIFY_EN
    assign verify_stop = meas_pass;
`else
    assign verify_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cmd_ready  <= 1'b1;
            sh_clk     <= 1'b0;
            sh_data    <= 1'b0;
            sh_latch   <= 1'b0;
            mux_en     <= 1'b0;
            prog_inj   <= 1'b0;
            prog_tun   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_abort  <= 1'b0;
            rsp_count  <= 8'd0;
            timer_reg  <= '0;
            step_reg   <= '0;
            word_reg   <= '0;
            op_reg     <= 1'b0;
            pulses_reg <= 8'd0;
            issued_reg <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            sh_latch  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        op_reg     <= cmd_op;
                        pulses_reg <= cmd_pulses;
                        issued_reg <= 8'd0;
                        word_reg   <= {cmd_row, cmd_col};
                        rsp_abort  <= 1'b0;
                        rsp_count  <= 8'd0;
                        if (addr_bad) begin
                            state_reg <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                            rsp_err   <= 1'b0;
                            step_reg  <= '0;
                            sh_clk    <= 1'b0;
                            sh_data   <= cmd_row[ROW_W-1];
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_abort <= 1'b0;
                    rsp_count <= 8'd0;
                end
                default: begin
                    // abort outranks every natural transition, including the end of a pulse or gap
                    if (abort) begin
                        state_reg <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_abort <= 1'b1;
                        rsp_count <= issued_reg;
                        sh_clk    <= 1'b0;
                        sh_data   <= 1'b0;
                        mux_en    <= 1'b0;
                        prog_inj  <= 1'b0;
                        prog_tun  <= 1'b0;
                    end else begin
                        case (state_reg)
                            SHIFT: begin
                                step_reg <= step_reg + 1'b1;
                                if (!step_reg[0]) begin
                                    sh_clk <= 1'b1;
                                end else begin
                                    sh_clk <= 1'b0;
                                    if (step_reg == STEP_LAST) begin
                                        state_reg <= LATCH;
                                        sh_latch  <= 1'b1;
                                    end else begin
                                        sh_data  <= word_reg[ADDR_W-2];
                                        word_reg <= word_reg << 1;
                                    end
                                end
                            end
                            LATCH: begin
                                state_reg <= SETTLE;
                                sh_data   <= 1'b0;
                                mux_en    <= 1'b1;
                                timer_reg <= SETTLE_LOAD;
                            end
                            SETTLE: begin
                                if (timer_reg != '0) begin
                                    timer_reg <= timer_reg - 1'b1;
                                end else if (pulses_reg == 8'd0) begin
                                    state_reg <= DONE;
                                    rsp_valid <= 1'b1;
                                    rsp_count <= issued_reg;
                                    mux_en    <= 1'b0;
                                end else begin
                                    state_reg <= PULSE;
                                    prog_inj  <= ~op_reg;
                                    prog_tun  <= op_reg;
                                    timer_reg <= PULSE_LOAD;
                                end
                            end
                            PULSE: begin
                                if (timer_reg != '0) begin
                                    timer_reg <= timer_reg - 1'b1;
                                end else begin
                                    state_reg  <= GAP;
                                    prog_inj   <= 1'b0;
                                    prog_tun   <= 1'b0;
                                    issued_reg <= issued_reg + 8'd1;
                                    timer_reg  <= GAP_LOAD;
                                end
                            end
                            GAP: begin
                                if (timer_reg != '0) begin
                                    timer_reg <= timer_reg - 1'b1;
                                end else if ((issued_reg == pulses_reg) || verify_stop) begin
                                    state_reg <= DONE;
                                    rsp_valid <= 1'b1;
                                    rsp_count <= issued_reg;
                                    mux_en    <= 1'b0;
                                end else begin
                                    state_reg <= PULSE;
                                    prog_inj  <= ~op_reg;
                                    prog_tun  <= op_reg;
                                    timer_reg <= PULSE_LOAD;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Randomized bench for fg_prog_sequencer: each command's trace is reduced to counts and
// compared against a timeline model derived from the phase lengths (FG_PROG_VERIFY_EN aware).
`timescale 1ns/1ps
module tb_fg_prog_sequencer;

    localparam int T_FIRST = 16 + 1 + 8;   // cycles before the first pulse starts
    localparam int T_PER   = 100 + 20;     // one pulse plus its gap

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_row;
    logic [4:0] cmd_col;
    logic       cmd_op;
    logic [7:0] cmd_pulses;
    logic       abort;
`ifdef FG_PROG_VERIFY_EN
    logic       meas_pass;
`endif
    logic       sh_clk, sh_data, sh_latch, mux_en, prog_inj, prog_tun;
    logic       rsp_valid, rsp_err, rsp_abort;
    logic [7:0] rsp_count;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fg_prog_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_op     (cmd_op),
        .cmd_pulses (cmd_pulses),
        .abort      (abort),
`ifdef FG_PROG_VERIFY_EN
        .meas_pass  (meas_pass),
`endif
        .sh_clk     (sh_clk),
        .sh_data    (sh_data),
        .sh_latch   (sh_latch),
        .mux_en     (mux_en),
        .prog_inj   (prog_inj),
        .prog_tun   (prog_tun),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_abort  (rsp_abort),
        .rsp_count  (rsp_count)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        compared++;
        if (obs != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // abort_at: cycle index after accept during which abort is high (-1 = never)
    // meas_gap: index of the gap during which meas_pass is held high (-1 = never)
    task automatic run_cmd(input int row, input int col, input int op, input int pulses,
                           input int abort_at, input int meas_gap, input bit abort_on_accept);
        bit   err, aborted, got, prev_clk, prev_pulse, p, other;
        int   d_exp, n_eff, t_nat, cnt_exp, starts_exp, high_exp, s, e, nb_exp, word;
        int   cyc, starts_obs, high_obs, wrong_obs, mux_obs, latch_obs, nbits, ready_busy, bits_obs;

        err     = (row >= 5) || (col >= 26);
        aborted = 1'b0;
        n_eff   = pulses;
`ifdef FG_PROG_VERIFY_EN
        if (meas_gap >= 0 && meas_gap + 1 < pulses) n_eff = meas_gap + 1;
`endif
        if (err) begin
            d_exp = 0;
            n_eff = 0;
        end else begin
            t_nat = T_FIRST + n_eff * T_PER;
            d_exp = t_nat;
            if (abort_at >= 0 && abort_at < t_nat) begin
                d_exp   = abort_at + 1;
                aborted = 1'b1;
            end
        end
        cnt_exp = 0; starts_exp = 0; high_exp = 0;
        for (int k = 0; k < n_eff; k++) begin
            s = T_FIRST + k * T_PER;
            e = s + 99;
            if (!aborted || e < abort_at) cnt_exp++;
            if (s < d_exp) begin
                starts_exp++;
                high_exp += ((s + 100 < d_exp) ? s + 100 : d_exp) - s;
            end
        end
        nb_exp = (d_exp / 2 < 8) ? d_exp / 2 : 8;
        word   = (row * 32 + col) & 8'hFF;

        @(negedge clk);
        check_val("ready_idle", int'(cmd_ready), 1);
        cmd_valid  = 1'b1;
        cmd_row    = 3'(row);
        cmd_col    = 5'(col);
        cmd_op     = op[0];
        cmd_pulses = 8'(pulses);
        abort      = abort_on_accept;
        @(negedge clk);
        cmd_valid = 1'b0;
        abort     = 1'b0;

        cyc = 0; got = 0; prev_clk = 0; prev_pulse = 0;
        starts_obs = 0; high_obs = 0; wrong_obs = 0; mux_obs = 0; latch_obs = 0;
        nbits = 0; ready_busy = 0; bits_obs = 0;
        while (!got && cyc < 40000) begin
            if (cmd_ready) ready_busy++;
            if (sh_clk && !prev_clk) begin
                bits_obs = ((bits_obs << 1) | int'(sh_data)) & 8'hFF;
                nbits++;
            end
            prev_clk = sh_clk;
            p     = op[0] ? prog_tun : prog_inj;
            other = op[0] ? prog_inj : prog_tun;
            if (p && !prev_pulse) starts_obs++;
            if (p) high_obs++;
            prev_pulse = p;
            if (other) wrong_obs++;
            if (mux_en) mux_obs++;
            if (sh_latch) latch_obs++;
            abort = (cyc == abort_at);
`ifdef FG_PROG_VERIFY_EN
            meas_pass = (meas_gap >= 0) && (cyc >= T_FIRST + meas_gap * T_PER + 100)
                        && (cyc <= T_FIRST + meas_gap * T_PER + 119);
`endif
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
`ifdef FG_PROG_VERIFY_EN
        meas_pass = 1'b0;
`endif
        if (!got) begin
            check_val("rsp_timeout", 0, 1);
        end else begin
            check_val("latency",    cyc + 1, d_exp + 1);
            check_val("rsp_err",    int'(rsp_err), int'(err));
            check_val("rsp_abort",  int'(rsp_abort), int'(aborted));
            check_val("rsp_count",  int'(rsp_count), cnt_exp);
        end
        check_val("shift_bits",  nbits, nb_exp);
        check_val("shift_data",  bits_obs, word >> (8 - nb_exp));
        check_val("latch_cnt",   latch_obs, (d_exp > 16) ? 1 : 0);
        check_val("mux_cycles",  mux_obs, (d_exp > 17) ? d_exp - 17 : 0);
        check_val("pulse_starts", starts_obs, starts_exp);
        check_val("pulse_high",  high_obs, high_exp);
        check_val("wrong_pulse", wrong_obs, 0);
        check_val("ready_busy",  ready_busy, 0);
        $display("cmd row=%0d col=%0d op=%0d pulses=%0d abort_at=%0d -> err=%0d abort=%0d count=%0d latency=%0d",
                 row, col, op, pulses, abort_at, rsp_err, rsp_abort, rsp_count, cyc + 1);
    endtask

    initial begin
        int seen, row, col, pulses, abort_at, meas_gap;
        rst = 1'b1; cmd_valid = 1'b0; cmd_row = '0; cmd_col = '0; cmd_op = 1'b0;
        cmd_pulses = '0; abort = 1'b0;
`ifdef FG_PROG_VERIFY_EN
        meas_pass = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset_ready", int'(cmd_ready), 1);
        check_val("reset_outs", int'({sh_clk, sh_data, sh_latch, mux_en, prog_inj, prog_tun,
                                      rsp_valid, rsp_err, rsp_abort}), 0);
        check_val("reset_count", int'(rsp_count), 0);

        run_cmd(2, 17, 0, 3, -1, -1, 1'b0);    // reference shift pattern and 386-cycle latency
        run_cmd(5, 0, 0, 3, -1, -1, 1'b0);     // row out of range
        run_cmd(0, 26, 1, 1, -1, -1, 1'b0);    // column out of range
        run_cmd(1, 4, 1, 0, -1, -1, 1'b0);     // address select only
        run_cmd(3, 9, 1, 5, T_FIRST + T_PER + 30, -1, 1'b0);   // abort in second pulse
        run_cmd(0, 0, 0, 2, T_FIRST + 2 * T_PER - 1, -1, 1'b1); // abort on last gap cycle
        run_cmd(4, 25, 0, 1, T_FIRST + T_PER, -1, 1'b0);        // abort in DONE: ignored
`ifdef FG_PROG_VERIFY_EN
        run_cmd(1, 1, 0, 10, -1, 3, 1'b0);     // early stop after the 4th pulse
`endif

        // reset while a pulse is in progress
        @(negedge clk);
        abort = 1'b0;
        cmd_valid = 1'b1; cmd_row = 3'd1; cmd_col = 5'd3; cmd_op = 1'b0; cmd_pulses = 8'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (59) @(negedge clk);
        check_val("rst_pulse_on", int'(prog_inj), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_inj_drop", int'(prog_inj), 0);
        check_val("rst_mux_drop", int'(mux_en), 0);
        check_val("rst_ready", int'(cmd_ready), 1);
        check_val("rst_rsp", int'(rsp_valid), 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_val("rst_no_rsp", seen, 0);
        $display("reset mid-pulse -> rsp_seen=%0d", seen);

        for (int i = 0; i < 24; i++) begin
            row    = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 4) : $urandom_range(0, 7);
            col    = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 25) : $urandom_range(0, 31);
            pulses = $urandom_range(0, 3);
            abort_at = ($urandom_range(0, 1) != 0) ? -1
                       : $urandom_range(0, T_FIRST + pulses * T_PER + 2);
            meas_gap = -1;
`ifdef FG_PROG_VERIFY_EN
            if ($urandom_range(0, 2) == 0 && pulses > 0) meas_gap = $urandom_range(0, pulses - 1);
`endif
            run_cmd(row, col, $urandom_range(0, 1), pulses, abort_at, meas_gap,
                    1'($urandom_range(0, 1)));
        end

        run_cmd(4, 25, 1, 255, -1, -1, 1'b0);  // maximum pulse count

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
